multicycle_ctl: RTL and testbench

Parametrised main sequencer for the multicycle RV32I core, successor to the fixed five-state controller. It adds opcode-dependent paths: memory access, branch/jump PC load, optional single-cycle ALU retire. It also adds a ready/valid memory handshake with a wait-state timeout, a sticky trap state, and retire/cycle counters. It sits between the instruction register/decoder and the datapath enables (PC, memory port, register file, ALU).

---
 rtl/multicycle_ctl_pkg.sv | 63 ++++++
 rtl/bus_wait_timer.sv | 39 +++
 rtl/multicycle_ctl.sv | 159 +++++++++++++++
 tb/tb_multicycle_ctl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctl_pkg.sv
// Shared types for the multicycle RV32I sequencer: states, datapath strobes, trap causes,
// instruction layout and the base opcode constants.
package multicycle_ctl_pkg;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_TRAP
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE        = 2'd0,
    CAUSE_ILLEGAL     = 2'd1,
    CAUSE_BUS_TIMEOUT = 2'd2,
    CAUSE_ENV         = 2'd3
  } trap_cause_t;

  typedef struct packed {
    logic fetch_en;
    logic mem_req;
    logic mem_we;
    logic instrdec_ce;
    logic pc_inc;
    logic pc_load;
    logic alu_en;
    logic gp_regfile_we;
  } ctl_signals_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // SYSTEM is recognised here; it is routed to TRAP separately as an environment call.
  function automatic logic is_known_opc(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_FENCE, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Counts memory wait cycles; expired is asserted on the wait cycle that reaches the limit.
// Holds while ce is low; clear has priority over run.
module bus_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (ce) begin
      cnt_q <= cnt_d;
    end
  end

  // A ready on the limit cycle drops run, so the normal transition wins.
  assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctl.sv
// Main sequencer for the multicycle RV32I core: opcode-dependent fetch/decode/execute/memory/
// writeback paths, bus wait timeout, sticky trap, cycle and retire counters.
module multicycle_ctl
  import multicycle_ctl_pkg::*;
#(
  parameter bit          FAST_ALU_WB    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  instr_t           instr,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output ctl_signals_t     ctl_signals,
  output logic             retire,
  output logic             trap,
  output trap_cause_t      trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t           state_q, state_d;
  trap_cause_t      cause_q, cause_d;
  logic [CNT_W-1:0] cycle_q, instret_q;
  ctl_signals_t     ctl;
  logic             ret;
  logic             wait_run, wait_clear, wait_expired;
  logic [6:0]       opc;
  logic             is_alu;
  logic             unused_instr;

  assign opc          = instr.opcode;
  assign unused_instr = ^instr[31:7];
  assign is_alu       = (opc == OPC_LUI) || (opc == OPC_AUIPC) ||
                        (opc == OPC_OP)  || (opc == OPC_OP_IMM);

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    ctl      = '0;
    ret      = 1'b0;
    wait_run = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        ctl.fetch_en = 1'b1;
        ctl.mem_req  = 1'b1;
        wait_run     = !mem_ready;
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_BUS_TIMEOUT;
        end
      end
      ST_DECODE: begin
        ctl.instrdec_ce = 1'b1;
        ctl.pc_inc      = 1'b1;
        if (opc == OPC_SYSTEM) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ENV;
        end else if (!is_known_opc(opc)) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        ctl.alu_en = 1'b1;
        if (opc == OPC_LOAD || opc == OPC_STORE) begin
          state_d = ST_MEMORY;
        end else if (opc == OPC_BRANCH) begin
          ctl.pc_load = branch_taken;
          ret         = 1'b1;
          state_d     = ST_FETCH;
        end else if (opc == OPC_JAL || opc == OPC_JALR) begin
          ctl.pc_load = 1'b1;
          state_d     = ST_WRITEBACK;
        end else if (opc == OPC_FENCE) begin
          ret     = 1'b1;
          state_d = ST_FETCH;
        end else if (is_alu && FAST_ALU_WB) begin
          ctl.gp_regfile_we = 1'b1;
          ret               = 1'b1;
          state_d           = ST_FETCH;
        end else if (is_alu) begin
          state_d = ST_WRITEBACK;
        end else begin
          // Instruction register changed under us after decode: treat as illegal.
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_MEMORY: begin
        ctl.mem_req = 1'b1;
        ctl.mem_we  = (opc == OPC_STORE);
        wait_run    = !mem_ready;
        if (mem_ready) begin
          ret     = (opc == OPC_STORE);
          state_d = (opc == OPC_STORE) ? ST_FETCH : ST_WRITEBACK;
        end else if (wait_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_BUS_TIMEOUT;
        end
      end
      ST_WRITEBACK: begin
        ctl.gp_regfile_we = 1'b1;
        ret               = 1'b1;
        state_d           = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_RESET;
    endcase
  end

  assign wait_clear = (state_d != state_q);

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timer
      bus_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .ce      (ce),
        .run     (wait_run),
        .clear   (wait_clear),
        .expired (wait_expired)
      );
    end else begin : g_no_timer
      logic unused_timer;
      assign unused_timer = wait_run ^ wait_clear;
      assign wait_expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RESET;
      cause_q   <= CAUSE_NONE;
      cycle_q   <= '0;
      instret_q <= '0;
    end else if (ce) begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_q != ST_TRAP) cycle_q <= cycle_q + CNT_W'(1);
      if (ret) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign ctl_signals = ce ? ctl : '0;
  assign retire      = ce && ret;
  assign trap        = ce && (state_q == ST_TRAP);
  assign trap_cause  = cause_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_multicycle_ctl.sv
// Randomized scoreboard bench for multicycle_ctl: per-cycle expected outputs from a phase
// table, plus retire latency from the spec's cycle-count formula.
module tb_multicycle_ctl;
  import multicycle_ctl_pkg::*;

  localparam bit FAST = 1'b1;
  localparam int TMO  = 4;
  localparam int CW   = 8;

  typedef enum logic [2:0] {K_RST, K_F, K_D, K_E, K_M, K_W, K_T} kind_e;
  typedef struct packed {
    kind_e        kind;
    ctl_signals_t ctl;
    logic         ret;
    logic         trap;
    logic [1:0]   cause;
    logic [CW-1:0] cyc;
    logic [CW-1:0] icnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, ce, branch_taken, mem_ready;
  instr_t        instr;
  ctl_signals_t  ctl_signals;
  logic          retire, trap;
  trap_cause_t   trap_cause;
  logic [CW-1:0] cycle_cnt, instret_cnt;

  multicycle_ctl #(.FAST_ALU_WB(FAST), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .ce           (ce),
    .instr        (instr),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .ctl_signals  (ctl_signals),
    .retire       (retire),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  always #5 clk = ~clk;

  exp_t          sb[$];
  int            rq[$];
  logic [CW-1:0] m_cyc, m_ret;
  logic [1:0]    m_cause;
  int            n_chk = 0, n_fail = 0;

  function automatic bit is_alu(input logic [6:0] o);
    return o == OPC_LUI || o == OPC_AUIPC || o == OPC_OP || o == OPC_OP_IMM;
  endfunction
  function automatic bit is_mem(input logic [6:0] o);
    return o == OPC_LOAD || o == OPC_STORE;
  endfunction
  function automatic bit is_jmp(input logic [6:0] o);
    return o == OPC_JAL || o == OPC_JALR;
  endfunction

  function automatic int base_lat(input logic [6:0] o);
    if (is_alu(o)) return FAST ? 3 : 4;
    if (o == OPC_BRANCH || o == OPC_FENCE) return 3;
    if (o == OPC_LOAD) return 5;
    return 4;
  endfunction

  function automatic exp_t model(input kind_e k, input logic [6:0] o, input logic tk,
                                 input logic rdy, input logic cev);
    exp_t e;
    e = '0;
    e.kind = k; e.cause = m_cause; e.cyc = m_cyc; e.icnt = m_ret;
    if (cev) begin
      case (k)
        K_F: begin e.ctl.fetch_en = 1'b1; e.ctl.mem_req = 1'b1; end
        K_D: begin e.ctl.instrdec_ce = 1'b1; e.ctl.pc_inc = 1'b1; end
        K_E: begin
          e.ctl.alu_en        = 1'b1;
          e.ctl.pc_load       = (o == OPC_BRANCH) ? tk : is_jmp(o);
          e.ctl.gp_regfile_we = is_alu(o) && FAST;
          e.ret = (o == OPC_BRANCH) || (o == OPC_FENCE) || (is_alu(o) && FAST);
        end
        K_M: begin
          e.ctl.mem_req = 1'b1;
          e.ctl.mem_we  = (o == OPC_STORE);
          e.ret         = (o == OPC_STORE) && rdy;
        end
        K_W: begin e.ctl.gp_regfile_we = 1'b1; e.ret = 1'b1; end
        K_T: e.trap = 1'b1;
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic step(input kind_e k, input logic [6:0] o, input logic tk,
                      input logic rdy, input logic cev);
    exp_t e;
    ce = cev;
    mem_ready = rdy;
    branch_taken = (k == K_E) ? tk : 1'($urandom);
    e = model(k, o, tk, rdy, cev);
    sb.push_back(e);
    @(posedge clk); #1;
    if (cev && k != K_T) m_cyc = m_cyc + CW'(1);
    if (e.ret) m_ret = m_ret + CW'(1);
  endtask

  task automatic do_reset();
    reset = 1'b1; ce = 1'($urandom); mem_ready = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_cyc = '0; m_ret = '0; m_cause = 2'd0;
    step(K_RST, 7'd0, 1'b0, 1'($urandom), 1'b1);
  endtask

  task automatic run_instr(input logic [6:0] o, input int wf, input int wm,
                           input logic tk, input bit gap);
    instr = instr_t'($urandom);
    instr.opcode = o;
    rq.push_back(base_lat(o) + wf + (is_mem(o) ? wm + int'(gap) : 0));
    for (int i = 0; i < wf; i++) step(K_F, o, tk, 1'b0, 1'b1);
    step(K_F, o, tk, 1'b1, 1'b1);
    step(K_D, o, tk, 1'($urandom), 1'b1);
    step(K_E, o, tk, 1'($urandom), 1'b1);
    if (is_mem(o)) begin
      for (int j = 0; j < wm; j++) step(K_M, o, tk, 1'b0, 1'b1);
      if (gap) step(K_M, o, tk, 1'b1, 1'b0);
      step(K_M, o, tk, 1'b1, 1'b1);
    end
    if (o == OPC_LOAD || is_jmp(o) || (is_alu(o) && !FAST))
      step(K_W, o, tk, 1'($urandom), 1'b1);
  endtask

  task automatic trap_run(input logic [1:0] c);
    m_cause = c;
    for (int i = 0; i < 10; i++) begin
      instr = instr_t'($urandom);
      step(K_T, instr.opcode, 1'b0, 1'($urandom), (i == 5) ? 1'b0 : 1'b1);
    end
  endtask

  // Monitor: per-cycle scoreboard and retire-latency check
  int   lat = 0;
  logic prev_fetch = 1'b0;
  always @(negedge clk) begin
    exp_t e, a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '0;
      a.kind = e.kind; a.ctl = ctl_signals; a.ret = retire; a.trap = trap;
      a.cause = trap_cause; a.cyc = cycle_cnt; a.icnt = instret_cnt;
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle phase=%0d t=%0t: got ctl=%b ret=%b trap=%b cause=%0d cyc=%0d icnt=%0d, want ctl=%b ret=%b trap=%b cause=%0d cyc=%0d icnt=%0d",
                 e.kind, $time, a.ctl, a.ret, a.trap, a.cause, a.cyc, a.icnt,
                 e.ctl, e.ret, e.trap, e.cause, e.cyc, e.icnt);
      end
    end
    if (reset) begin
      prev_fetch = 1'b0;
    end else begin
      if (ctl_signals.fetch_en && !prev_fetch) lat = 1;
      else lat++;
      prev_fetch = ctl_signals.fetch_en;
      if (retire === 1'b1) begin
        n_chk++;
        if (rq.size() == 0) begin
          n_fail++;
          $display("FAIL retire_unexpected t=%0t: got retire=1, want no retire", $time);
        end else begin
          int want;
          want = rq.pop_front();
          if (lat != want) begin
            n_fail++;
            $display("FAIL retire_latency t=%0t: got %0d cycles, want %0d", $time, lat, want);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  logic [6:0] legal [10];
  initial begin
    legal = '{OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
              OPC_FENCE, OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM};
    reset = 1'b1; ce = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0; instr = '0;
    m_cyc = '0; m_ret = '0; m_cause = 2'd0;

    do_reset();
    run_instr(OPC_OP_IMM, 0, 0, 1'b0, 1'b0);
    run_instr(OPC_LOAD,   0, 2, 1'b0, 1'b0);
    run_instr(OPC_BRANCH, 0, 0, 1'b0, 1'b0);
    run_instr(OPC_BRANCH, 0, 0, 1'b1, 1'b0);
    run_instr(OPC_STORE,  0, 1, 1'b0, 1'b0);
    run_instr(OPC_STORE,  0, 1, 1'b0, 1'b1);
    run_instr(OPC_JAL,    1, 0, 1'b0, 1'b0);
    run_instr(OPC_FENCE,  TMO - 1, 0, 1'b0, 1'b0);
    run_instr(OPC_LOAD,   0, TMO - 1, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++)
      run_instr(legal[$urandom_range(0, 9)], $urandom_range(0, TMO - 1),
                $urandom_range(0, TMO - 1), 1'($urandom), ($urandom_range(0, 3) == 0));

    // Reset mid-wait must also clear the wait timer.
    instr = instr_t'($urandom); instr.opcode = OPC_LOAD;
    step(K_F, OPC_LOAD, 1'b0, 1'b0, 1'b1);
    step(K_F, OPC_LOAD, 1'b0, 1'b0, 1'b1);
    do_reset();
    run_instr(OPC_LOAD, TMO - 1, TMO - 1, 1'b0, 1'b0);

    // Fetch timeout
    instr = instr_t'($urandom); instr.opcode = OPC_OP;
    for (int i = 0; i < TMO; i++) step(K_F, OPC_OP, 1'b0, 1'b0, 1'b1);
    trap_run(2'd2);
    do_reset();

    // Memory timeout on a store
    instr = instr_t'($urandom); instr.opcode = OPC_STORE;
    step(K_F, OPC_STORE, 1'b0, 1'b1, 1'b1);
    step(K_D, OPC_STORE, 1'b0, 1'b0, 1'b1);
    step(K_E, OPC_STORE, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < TMO; i++) step(K_M, OPC_STORE, 1'b0, 1'b0, 1'b1);
    trap_run(2'd2);
    do_reset();

    // Illegal opcode 0
    run_instr(OPC_OP, 0, 0, 1'b0, 1'b0);
    instr = instr_t'($urandom & 32'hFFFF_FF80);
    step(K_F, 7'd0, 1'b0, 1'b1, 1'b1);
    step(K_D, 7'd0, 1'b0, 1'b1, 1'b1);
    trap_run(2'd1);
    do_reset();

    // ECALL, then EBREAK
    instr = instr_t'(32'h0000_0073);
    step(K_F, OPC_SYSTEM, 1'b0, 1'b1, 1'b1);
    step(K_D, OPC_SYSTEM, 1'b0, 1'b0, 1'b1);
    trap_run(2'd3);
    do_reset();
    instr = instr_t'(32'h0010_0073);
    step(K_F, OPC_SYSTEM, 1'b0, 1'b1, 1'b1);
    step(K_D, OPC_SYSTEM, 1'b0, 1'b0, 1'b1);
    trap_run(2'd3);
    do_reset();
    run_instr(OPC_AUIPC, 0, 0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    n_chk++;
    if (sb.size() != 0 || rq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d cycle and %0d retire expectations left, want 0 and 0",
               sb.size(), rq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
